// File: rtl/mem_responder.sv
// Load/store memory responder: serialized byte/halfword/word accesses with a fixed wait-state latency.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned or reserved-size requests instead of force-aligning them.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                commit;

  logic [31:0]         mem [2**ADDR_W];
  logic [ADDR_W-1:0]   widx;
  logic [1:0]          lane;
  logic [1:0]          sz_eff;
  logic                bad;
  logic [3:0]          be;
  logic [31:0]         wword, rword, rsel;

  // Address bits above the array span alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    widx  = addr_q[ADDR_W+1:2];
    lane  = addr_q[1:0];
`ifdef MEM_ALIGN_CHECK_EN
    sz_eff = size_q;
    bad    = (size_q == 2'b11) | ((size_q == 2'b01) & lane[0]) |
             ((size_q == 2'b10) & (lane != 2'b00));
`else
    sz_eff = (size_q == 2'b11) ? 2'b10 : size_q;
    bad    = 1'b0;
`endif
    rword = mem[widx];
    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (sz_eff)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
        rsel  = {24'b0, rword[{lane, 3'b000} +: 8]};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
        rsel  = {16'b0, rword[{lane[1], 4'b0000} +: 16]};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
        rsel  = rword;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_WAIT;
        cnt_d   = 4'(LATENCY);
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = S_RESP;
          rdata_d = (we_q | bad) ? 32'h0 : rsel;
          err_d   = bad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is never reset; a write lands only on its commit edge.
  always_ff @(posedge clk) begin
    if (commit && reset && we_q && !bad) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a byte-addressed reference model and a per-cycle checker.
module tb_mem_responder;
  localparam int AW  = 8;
  localparam int LAT = 2;
  localparam int MB  = 1 << (AW + 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          acc;
  } txn_t;

  txn_t        q[$];
  logic [7:0]  mb [MB];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: which bytes an access touches, from the byte address and size.
  function automatic void locate(input logic [1:0] sz, input logic [31:0] addr,
                                 output int base, output int nb, output logic err);
    int a;
    a = int'(addr & 32'(MB - 1));
`ifdef MEM_ALIGN_CHECK_EN
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    nb  = (sz == 2'd3) ? 4 : (1 << sz);
`else
    err = 1'b0;
    nb  = (sz == 2'd3) ? 4 : (1 << sz);
    a   = a - (a % nb);
`endif
    base = a;
  endfunction

  task automatic push_txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd);
    txn_t t; int base, nb; logic err;
    locate(sz, addr, base, nb, err);
    t.we = we; t.sz = sz; t.addr = addr; t.wd = wd; t.exp_err = err; t.acc = cyc;
    t.exp_rd = 32'h0;
    if (!err && !we)
      for (int i = 0; i < nb; i++) t.exp_rd = t.exp_rd | (32'(mb[base + i]) << (8 * i));
    q.push_back(t);
  endtask

  task automatic retire();
    txn_t t; int base, nb; logic err;
    if (q.size() == 0) return;
    t = q.pop_front();
    locate(t.sz, t.addr, base, nb, err);
    if (t.we && !err)
      for (int i = 0; i < nb; i++) mb[base + i] = t.wd[8*i +: 8];
  endtask

  // Per-cycle checker: handshake outputs and response payload against the model.
  always begin
    @(negedge clk);
    if (reset) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() == 0});
      if (q.size() == 0)
        chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'h0);
      else begin
        chk("rsp_valid_timing", {31'b0, rsp_valid}, {31'b0, (cyc - q[0].acc) >= LAT});
        if (rsp_valid) begin
          chk("rsp_rdata", rsp_rdata, q[0].exp_rd);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].exp_err});
        end
      end
    end
    cyc++;
  end

  task automatic xfer(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input int rdly, input bit pulse,
                      output logic [31:0] rd, output logic er);
    int n;
    rd = 32'h0; er = 1'b0;
    req_we = we; req_size = sz; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin chk("req_ready_timeout", 32'h0, 32'h1); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    push_txn(we, sz, addr, wd);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin chk("rsp_valid_timeout", 32'h0, 32'h1); q.delete(); return; end
    for (int i = 0; i < rdly; i++) begin
      if (pulse && i == 1) begin
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h0; req_valid = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    retire();
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [31:0] rd; logic er;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    xfer(1'b1, 2'd2, 32'h10, 32'h01020304, 0, 1'b0, rd, er);

    // Reset in the middle of WAIT for a word write; the write must be dropped.
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    push_txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    req_valid = 1'b0;
    #3 reset = 1'b0;
    q.delete();
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    xfer(1'b0, 2'd2, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("rd_0x10_after_rst", rd, 32'h01020304);

    xfer(1'b1, 2'd2, 32'h20, 32'h11223344, 0, 1'b0, rd, er);
    chk("wr_rdata_zero", rd, 32'h0);
    xfer(1'b1, 2'd0, 32'h21, 32'h000000AA, 1, 1'b0, rd, er);
    xfer(1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("rd_0x20", rd, 32'h1122AA44);
    chk("rd_0x20_err", {31'b0, er}, 32'h0);
    xfer(1'b0, 2'd1, 32'h22, 32'h0, 0, 1'b0, rd, er);
    chk("rdh_0x22", rd, 32'h00001122);
    xfer(1'b0, 2'd0, 32'h23, 32'h0, 2, 1'b0, rd, er);
    chk("rdb_0x23", rd, 32'h00000011);

    xfer(1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, 0, 1'b0, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_err", {31'b0, er}, 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    xfer(1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("rd_0x20_kept", rd, 32'h1122AA44);
    xfer(1'b0, 2'd3, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("size3_err", {31'b0, er}, 32'h1);
    xfer(1'b0, 2'd1, 32'h21, 32'h0, 0, 1'b0, rd, er);
    chk("half_odd_err", {31'b0, er}, 32'h1);
`else
    chk("forced_align_err", {31'b0, er}, 32'h0);
    xfer(1'b0, 2'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("rd_0x20_forced", rd, 32'hFFFFFFFF);
    xfer(1'b1, 2'd1, 32'h23, 32'h0000ABCD, 0, 1'b0, rd, er);
    xfer(1'b0, 2'd3, 32'h21, 32'h0, 0, 1'b0, rd, er);
    chk("size3_as_word", rd, 32'hABCDFFFF);
`endif

    // Stall in RESP with a stray request pulse; checker verifies stability each cycle.
    xfer(1'b0, 2'd2, 32'h20, 32'h0, 5, 1'b1, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    chk("hold_rdata", rd, 32'h1122AA44);
`else
    chk("hold_rdata", rd, 32'hABCDFFFF);
`endif

    xfer(1'b1, 2'd2, 32'h400, 32'h5A5A5A5A, 0, 1'b0, rd, er);
    xfer(1'b0, 2'd2, 32'h000, 32'h0, 0, 1'b0, rd, er);
    chk("wrap_alias", rd, 32'h5A5A5A5A);

    xfer(1'b1, 2'd2, 32'h100, 32'hCAFEF00D, 0, 1'b0, rd, er);
    xfer(1'b1, 2'd1, 32'h102, 32'h1234BEEF, 0, 1'b0, rd, er);
    xfer(1'b1, 2'd0, 32'h100, 32'h00000077, 0, 1'b0, rd, er);
    xfer(1'b0, 2'd2, 32'h100, 32'h0, 3, 1'b0, rd, er);
    chk("merge_0x100", rd, 32'hBEEFF077);
    xfer(1'b0, 2'd0, 32'hFFFFF101, 32'h0, 0, 1'b0, rd, er);
    chk("hi_bits_ignored", rd, 32'h000000F0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
